// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// instruction-field codes, ALU controls, datapath mux selects and condition codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALU B operand and result-bus selects
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the control unit.
interface multicycle_ctrl_if ();

  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;

  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );

endinterface

// File: rtl/cond_logic.sv
// NZCV flag register, condition-code evaluation and gating of every
// architectural write enable.
module cond_logic
  import ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       reset_n,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       next_pc_i,
  input  logic       branch_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  input  logic       ir_w_i,
  input  logic       rd_pc_i,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       ir_write_o
);

  logic [1:0] nz_q;
  logic [1:0] cv_q;
  logic       cond_ex;
  logic       pcs;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      nz_q <= 2'b00;
      cv_q <= 2'b00;
    end else begin
      if (flag_w_i[1] && cond_ex) nz_q <= alu_flags_i[3:2];
      if (flag_w_i[0] && cond_ex) cv_q <= alu_flags_i[1:0];
    end
  end

  // NOTE: the default assignment ahead of the case keeps this block purely
  // combinational; any path leaving cond_ex unassigned would infer a latch.
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond_i)
      COND_EQ: cond_ex = nz_q[0];
      COND_NE: cond_ex = !nz_q[0];
      COND_CS: cond_ex = cv_q[1];
      COND_CC: cond_ex = !cv_q[1];
      COND_MI: cond_ex = nz_q[1];
      COND_PL: cond_ex = !nz_q[1];
      COND_VS: cond_ex = cv_q[0];
      COND_VC: cond_ex = !cv_q[0];
      COND_HI: cond_ex = cv_q[1] && !nz_q[0];
      COND_LS: cond_ex = !cv_q[1] || nz_q[0];
      COND_GE: cond_ex = nz_q[1] == cv_q[0];
      COND_LT: cond_ex = nz_q[1] != cv_q[0];
      COND_GT: cond_ex = !nz_q[0] && (nz_q[1] == cv_q[0]);
      COND_LE: cond_ex = nz_q[0] || (nz_q[1] != cv_q[0]);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // A register write to r15 is redirected to the PC write path.
  assign pcs         = branch_i | (reg_w_i & rd_pc_i);
  assign pc_write_o  = reset_n & (next_pc_i | (pcs & cond_ex));
  assign reg_write_o = reset_n & reg_w_i & cond_ex & !rd_pc_i;
  assign mem_write_o = reset_n & mem_w_i & cond_ex;
  assign ir_write_o  = reset_n & ir_w_i;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: main FSM plus ALU decoder; condition gating and
// flags live in cond_logic.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic               CLK,
  input  logic               reset_n,
  multicycle_ctrl_if.slave   bus
);

  state_e     state_q, state_d;
  logic       next_pc, branch, reg_w, mem_w, ir_w;
  logic [3:0] cmd;
  logic       cmd_ok, arith, in_exec;
  logic [1:0] alu_ctl;
  logic [1:0] flag_w;

  assign cmd     = bus.Funct[4:1];
  assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    next_pc       = 1'b0;
    branch        = 1'b0;
    reg_w         = 1'b0;
    mem_w         = 1'b0;
    ir_w          = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = SRCB_REG;
    bus.ResultSrc = RES_ALUOUT;
    unique case (state_q)
      S_FETCH: begin
        ir_w          = 1'b1;
        next_pc       = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALU;
        unique case (bus.Op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcB = SRCB_IMM;
        state_d     = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.AdrSrc = 1'b1;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        reg_w         = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        bus.AdrSrc = 1'b1;
        mem_w      = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR: state_d = S_ALUWB;
      S_EXECI: begin
        bus.ALUSrcB = SRCB_IMM;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = cmd_ok && (cmd != CMD_CMP);
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALU;
        branch        = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Unsupported commands fall back to ADD but never write a register.
  always_comb begin
    alu_ctl = ALU_ADD;
    cmd_ok  = 1'b1;
    arith   = 1'b0;
    unique case (cmd)
      CMD_ADD: begin alu_ctl = ALU_ADD; arith = 1'b1; end
      CMD_SUB: begin alu_ctl = ALU_SUB; arith = 1'b1; end
      CMD_CMP: begin alu_ctl = ALU_SUB; arith = 1'b1; end
      CMD_AND: alu_ctl = ALU_AND;
      CMD_ORR: alu_ctl = ALU_ORR;
      default: cmd_ok = 1'b0;
    endcase
  end

  assign bus.ALUControl = in_exec ? alu_ctl : ALU_ADD;
  assign flag_w         = (in_exec && bus.Funct[0]) ? {1'b1, arith} : 2'b00;
  assign bus.ImmSrc     = bus.Op;
  assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};

  cond_logic u_cond_logic (
    .CLK         (CLK),
    .reset_n     (reset_n),
    .cond_i      (bus.Cond),
    .alu_flags_i (bus.ALUFlags),
    .flag_w_i    (flag_w),
    .next_pc_i   (next_pc),
    .branch_i    (branch),
    .reg_w_i     (reg_w),
    .mem_w_i     (mem_w),
    .ir_w_i      (ir_w),
    .rd_pc_i     (bus.Rd == 4'hF),
    .pc_write_o  (bus.PCWrite),
    .reg_write_o (bus.RegWrite),
    .mem_write_o (bus.MemWrite),
    .ir_write_o  (bus.IRWrite)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by
// random instructions, each cycle compared against a cycle-indexed model.
module tb_multicycle_ctrl;

  logic CLK = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] flags_m;

  always #5 CLK = ~CLK;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic logic [15:0] observed();
    return {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite,
            bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
            bus.ImmSrc, bus.RegSrc, bus.ALUControl};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Condition table written straight from the architectural definitions.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Runs one instruction starting in its fetch cycle; abort_k >= 0 pulses
  // reset during that cycle index and abandons the instruction.
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                           input logic [5:0] funct, input logic [3:0] rd,
                           input logic [3:0] alu, input int abort_k = -1);
    logic [3:0] cmd;
    logic s_bit, i_bit, is_dp, is_mem, is_b, known, writes, arith, ce;
    logic regw_raw, pcw, memw, regw, adr, srca;
    logic [1:0] srcb, res, aluc, aluc_cmd;
    int n;
    bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.ALUFlags = alu;
    cmd    = funct[4:1];
    s_bit  = funct[0];
    i_bit  = funct[5];
    is_dp  = (op == 2'd0);
    is_mem = (op == 2'd1);
    is_b   = (op == 2'd2);
    arith  = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b1010);
    known  = arith || (cmd == 4'b0000) || (cmd == 4'b1100);
    writes = known && (cmd != 4'b1010);
    case (cmd)
      4'b0010, 4'b1010: aluc_cmd = 2'd1;
      4'b0000:          aluc_cmd = 2'd2;
      4'b1100:          aluc_cmd = 2'd3;
      default:          aluc_cmd = 2'd0;
    endcase
    if (op == 2'd3)      n = 2;
    else if (is_b)       n = 3;
    else if (is_mem)     n = s_bit ? 5 : 4;
    else                 n = 4;
    for (int k = 0; k < n; k++) begin
      ce       = cond_holds(cond, flags_m);
      regw_raw = (k == n - 1) && ((is_dp && writes) || (is_mem && s_bit));
      pcw      = (k == 0) || ((k == n - 1) && (is_b || (regw_raw && rd == 4'hF)) && ce);
      regw     = regw_raw && ce && (rd != 4'hF);
      memw     = is_mem && !s_bit && (k == 3) && ce;
      adr      = is_mem && (k == 3);
      srca     = (k <= 1);
      if (k <= 1)                     srcb = 2'b10;
      else if (k == 2 && is_dp)       srcb = i_bit ? 2'b01 : 2'b00;
      else if (k == 2)                srcb = 2'b01;
      else                            srcb = 2'b00;
      if (k <= 1 || (is_b && k == 2)) res = 2'b10;
      else if (is_mem && k == 4)      res = 2'b01;
      else                            res = 2'b00;
      aluc = (is_dp && k == 2) ? aluc_cmd : 2'b00;
      @(negedge CLK);
      check($sformatf("instr cond=%h op=%h funct=%h rd=%h cycle=%0d", cond, op, funct, rd, k),
            observed(),
            {pcw, memw, regw, (k == 0), adr, srca, srcb, res, op,
             (op == 2'd1), (op == 2'd2), aluc});
      if (k == abort_k) begin
        #1 reset_n = 1'b0;
        #1 check("reset_mid_instr", observed(),
                 {4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, op, (op == 2'd1), (op == 2'd2), 2'b00});
        flags_m = 4'b0000;
        @(posedge CLK);
        #1 reset_n = 1'b1;
        return;
      end
      if (is_dp && k == 2 && s_bit && ce) begin
        flags_m[3:2] = alu[3:2];
        if (arith) flags_m[1:0] = alu[1:0];
      end
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    logic [3:0] rc, rrd, ralu;
    logic [1:0] rop;
    logic [5:0] rf;
    reset_n = 1'b1;
    bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'h0; bus.ALUFlags = 4'h0;
    flags_m = 4'b0000;
    #3 reset_n = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_enables_and_fetch", observed(),
          {4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00});
    @(posedge CLK);
    #1 reset_n = 1'b1;

    // ADD r1,r2,#5
    run_instr(4'hE, 2'b00, 6'b101000, 4'h1, 4'hF);
    // SUBS setting Z, then BEQ taken; then SUBS clearing Z, BEQ not taken
    run_instr(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0100);
    run_instr(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0);
    run_instr(4'hE, 2'b00, 6'b000101, 4'h2, 4'b0000);
    run_instr(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0);
    // LDR, then STR that never executes
    run_instr(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0);
    run_instr(4'hF, 2'b01, 6'b011000, 4'h3, 4'h0);
    // CMP N,V set, then ADD LT suppressed
    run_instr(4'hE, 2'b00, 6'b010101, 4'h4, 4'b1001);
    run_instr(4'hB, 2'b00, 6'b101000, 4'h5, 4'h0);
    // ADD into PC, illegal opcode, unsupported command
    run_instr(4'hE, 2'b00, 6'b001000, 4'hF, 4'h0);
    run_instr(4'hE, 2'b11, 6'b000000, 4'h1, 4'h0);
    run_instr(4'hE, 2'b00, 6'b111111, 4'h6, 4'b1111);
    // STR abandoned by reset while in its write cycle, then a fresh ADD
    run_instr(4'hE, 2'b01, 6'b011000, 4'h7, 4'h0, 3);
    run_instr(4'hE, 2'b00, 6'b101000, 4'h1, 4'h0);

    for (int i = 0; i < 400; i++) begin
      rc   = 4'($urandom_range(0, 15));
      rop  = 2'($urandom_range(0, 3));
      rf   = 6'($urandom_range(0, 63));
      rrd  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      ralu = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) rc = 4'hE;
      run_instr(rc, rop, rf, rrd, ralu);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the multicycle ARM-subset datapath. It decodes the instruction latched in the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback. It drives the write-enables (`PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`) and mux selects of the enable-register stages that hold PC, instruction, data and ALU result. It also holds the NZCV flags and evaluates condition codes, gating every architectural write.

## Interface
- No parameters; all encodings are fixed.
- `CLK` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous reset, active-low.
- `Cond` in 4: instr[31:28].
- `Op` in 2: instr[27:26]. 00 = data-processing, 01 = memory, 10 = branch, 11 = illegal.
- `Funct` in 6: instr[25:20]. [5] = I (immediate); [4:1] = cmd; [0] = S for data-processing, L for memory.
- `Rd` in 4: instr[15:12].
- `ALUFlags` in 4: {N,Z,C,V} from the ALU, same cycle.
- `PCWrite`, `MemWrite`, `RegWrite`, `IRWrite` out 1: write-enables, already condition-gated.
- `AdrSrc`, `ALUSrcA` out 1: address select (0 = PC, 1 = ALUOut); ALU A select (1 = PC).
- `ALUSrcB`, `ResultSrc`, `ImmSrc`, `RegSrc`, `ALUControl` out 2 each.

## Operation
- State register, states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: `IRWrite`=1, NextPC=1, `AdrSrc`=0, `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10, `ALUControl`=00. Always goes to DECODE.
- DECODE: `ALUSrcA`=1, `ALUSrcB`=10, `ResultSrc`=10.
  - Op=01 → MEMADR.
  - Op=00 → EXECI if Funct[5]=1, else EXECR.
  - Op=10 → BRANCH.
  - Op=11 → FETCH, with no writes.
- MEMADR: `ALUSrcB`=01. Goes to MEMRD if L=1, else MEMWR.
- MEMRD: `AdrSrc`=1, then MEMWB. MEMWB: `ResultSrc`=01, RegW=1, then FETCH.
- MEMWR: `AdrSrc`=1, MemW=1, then FETCH.
- EXECR: `ALUSrcB`=00. EXECI: `ALUSrcB`=01. Both go to ALUWB.
- ALUWB: `ResultSrc`=00. RegW=1 unless cmd=1010 (CMP). Then FETCH.
- BRANCH: `ALUSrcB`=01, `ResultSrc`=10, Branch=1, then FETCH.
- ALUControl, applied in EXEC states only:
  - cmd 0100 → 00 (ADD); 0010 and 1010 → 01 (SUB); 0000 → 10 (AND); 1100 → 11 (ORR).
  - Any other cmd → 00, with RegW suppressed.
- ImmSrc = Op. RegSrc = {Op==01, Op==10}.
- FlagW is active in the EXEC states only, when S=1. FlagW[1] updates N,Z; FlagW[0] updates C,V and is set only for ADD, SUB and CMP.
- CondEx is combinational from `Cond` and the registered flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1.
  - 1111 → 0.
- Gating:
  - PCS = Branch | (RegW & `Rd`==15).
  - `PCWrite` = NextPC | (PCS & CondEx).
  - `RegWrite` = RegW & CondEx & !(Rd==15 & MEMWB/ALUWB handled as PC). PC-destination writes go through `PCWrite` only.
  - `MemWrite` = MemW & CondEx.
  - Flag update = FlagW & CondEx.

## Timing
- Moore FSM: all outputs derive from the current state plus the instruction fields. No output depends on the clocked next state.
- Cycles per instruction: B = 3; data-processing and STR = 4; LDR = 5; illegal Op = 2.
- Flags are written at the rising edge that ends an EXEC state. The new flags are visible to CondEx from the next cycle onward.
- Reset (`reset_n`=0): state = FETCH and flags = 0000 immediately. While `reset_n`=0, all four enables are forced to 0.
- The first FETCH executes on the first rising edge after `reset_n` rises.
- Reset mid-instruction abandons the instruction. No partial write occurs after assertion.

## Structure
- Package `ctrl_pkg` holds:
  - state enum;
  - Op encodings;
  - ALUControl codes;
  - cmd codes (ADD/SUB/AND/ORR/CMP);
  - condition-code constants.
- Sub-module `cond_logic` contains the 4-bit flag register (two 2-bit enable registers, NZ and CV, asynchronous active-low clear), CondEx decode and output gating.
- The top level holds the FSM and the ALU/control decoders.

## Test plan
- Reset held low, then released → state FETCH, all enables 0 during reset. `IRWrite`=1 and `PCWrite`=1 in the first cycle after release.
- ADD r1,r2,#5, AL (Op=00, Funct=101000) → states FETCH, DECODE, EXECI, ALUWB. `ALUControl`=00, `RegWrite`=1 only in ALUWB, flags unchanged.
- SUBS with `ALUFlags`=0100, then BEQ (Cond=0000, Op=10) → flags Z=1 and the branch takes: `PCWrite`=1 in BRANCH, 3 cycles. Repeat with `ALUFlags`=0000 → `PCWrite`=0 in BRANCH.
- LDR (Op=01, Funct=011001) → 5 cycles, `AdrSrc`=1 in MEMRD, `ResultSrc`=01 and `RegWrite`=1 in MEMWB. STR with Cond=1111 → `MemWrite` never asserted.
- CMP (cmd=1010, S=1), `ALUFlags`=1001 → `RegWrite`=0, flags become 1001. A following ADD with Cond=1011 (LT) is suppressed because N==V.
- `reset_n` pulsed low during MEMWR → `MemWrite` drops in the same cycle, state returns to FETCH.
